otter_fetch_stage: RTL and testbench

Instruction-fetch front end that replaces the hardwired PC/mem_read1 path of the pipelined OTTER. It owns the fetch PC and issues one instruction-memory read per cycle on memory port 1. It buffers returned words with their PC in a small FIFO and presents them to decode through a valid/ready handshake. A redirect from EX flushes everything younger and restarts fetch at the target.

---
 rtl/otter_pipe_pkg.sv | 15 +
 rtl/otter_fetch_stage_if.sv | 33 +++
 rtl/otter_fetch_fifo.sv | 70 +++++++
 rtl/otter_fetch_stage.sv | 105 ++++++++++
 tb/tb_otter_fetch_stage.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER pipeline front end.
//   fetch_entry_t : one buffered fetch result (instruction word plus its PC)
//   NOP_INSTR     : addi x0,x0,0, shown to decode when nothing is valid
//   PC_STEP       : sequential fetch increment in bytes
package otter_pipe_pkg;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/otter_fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory port 1, EX redirect
// and the decode stage.
//   master : fetch-stage side (drives memory request and decode head)
//   slave  : environment side (memory, EX and decode)
// Signals:
//   IMEM_REQ/IMEM_ADDR   read request to memory port 1
//   IMEM_RDATA           read data, returned one cycle after the request
//   REDIRECT/REDIRECT_PC taken branch/jump pulse and its target from EX
//   DE_VALID/DE_READY    decode handshake
//   DE_IR/DE_PC          head instruction and its PC
interface otter_fetch_stage_if;

    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        DE_VALID;
    logic        DE_READY;
    logic [31:0] DE_IR;
    logic [31:0] DE_PC;

    modport master (
        output IMEM_REQ, IMEM_ADDR, DE_VALID, DE_IR, DE_PC,
        input  IMEM_RDATA, REDIRECT, REDIRECT_PC, DE_READY
    );

    modport slave (
        input  IMEM_REQ, IMEM_ADDR, DE_VALID, DE_IR, DE_PC,
        output IMEM_RDATA, REDIRECT, REDIRECT_PC, DE_READY
    );

endinterface

// File: rtl/otter_fetch_fifo.sv
// Circular instruction buffer of fetch_entry_t.
// Ports:
//   CLK, RESET   clock, asynchronous active-low reset
//   push_i       write push_data_i at the tail
//   pop_i        drop the head entry
//   flush_i      empty the buffer; overrides push and pop
//   head_o       entry at the head (meaningful only when count_o != 0)
//   count_o      number of valid entries (0..DEPTH)
// The caller never pushes into a full buffer unless it pops in the same cycle.
module otter_fetch_fifo
    import otter_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output fetch_entry_t       head_o,
    output logic [PTR_W:0]     count_o
);

    fetch_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W:0]        count_q;
    logic [PTR_W:0]        count_d;

    // Occupancy next state: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch front end. Owns the fetch PC, issues at most one
// read per cycle to memory port 1, buffers returned words with their PC and
// hands them to decode with a valid/ready handshake. A REDIRECT pulse from EX
// flushes the buffer, drops the returning response and restarts at the target.
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous active-low reset
//   bus    otter_fetch_stage_if.master (memory port 1, redirect, decode)
module otter_fetch_stage
    import otter_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    otter_fetch_stage_if.master    bus
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      fetch_pc_q;
    logic [31:0]      fetch_pc_d;
    logic             inflight_q;
    logic             inflight_d;
    logic [31:0]      inflight_pc_q;
    logic [31:0]      inflight_pc_d;

    logic             redirect_s;
    logic             de_valid_s;
    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic [PTR_W+1:0] occ_s;
    logic [31:0]      req_addr_s;
    fetch_entry_t     push_data_s;
    fetch_entry_t     head_s;
    logic [PTR_W:0]   count_s;

    otter_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RESET       (RESET),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .flush_i     (redirect_s),
        .head_o      (head_s),
        .count_o     (count_s)
    );

    // Handshake, issue decision and request address.
    always_comb begin
        redirect_s = RESET & bus.REDIRECT;
        // Decode never sees a head during a redirect, so nothing pops then.
        de_valid_s = (count_s != (PTR_W+1)'(0)) & ~redirect_s;
        pop_s      = de_valid_s & bus.DE_READY;
        // Slots already committed after this cycle: buffered + returning - leaving.
        occ_s      = (PTR_W+2)'(count_s) + (PTR_W+2)'(inflight_q) - (PTR_W+2)'(pop_s);
        if (redirect_s) begin
            req_addr_s = bus.REDIRECT_PC & 32'hFFFF_FFFC;
            issue_s    = 1'b1;
        end else begin
            req_addr_s = fetch_pc_q;
            issue_s    = RESET & (occ_s < (PTR_W+2)'(DEPTH));
        end
        // A response returning in a redirect cycle belongs to the old stream.
        push_s           = inflight_q & ~redirect_s;
        push_data_s.ir   = bus.IMEM_RDATA;
        push_data_s.pc   = inflight_pc_q;
    end

    // Next state of the fetch PC and the single outstanding request.
    always_comb begin
        if (issue_s) begin
            fetch_pc_d    = req_addr_s + PC_STEP;
            inflight_pc_d = req_addr_s;
        end else begin
            fetch_pc_d    = fetch_pc_q;
            inflight_pc_d = inflight_pc_q;
        end
        inflight_d = issue_s;
    end

    // Fetch PC and inflight tracking registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            fetch_pc_q    <= RESET_VEC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign bus.IMEM_REQ  = issue_s;
    assign bus.IMEM_ADDR = req_addr_s;
    assign bus.DE_VALID  = de_valid_s;
    assign bus.DE_IR     = de_valid_s ? head_s.ir : NOP_INSTR;
    assign bus.DE_PC     = de_valid_s ? head_s.pc : 32'h0000_0000;

endmodule

// File: tb/tb_otter_fetch_stage.sv
module tb_otter_fetch_stage;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;

    otter_fetch_stage_if bus_a();
    otter_fetch_stage_if bus_b();

    otter_fetch_stage #(.RESET_VEC(32'h0000_0000), .DEPTH(2)) dut_a (
        .CLK   (clk),
        .RESET (rst_a),
        .bus   (bus_a)
    );

    otter_fetch_stage #(.RESET_VEC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (
        .CLK   (clk),
        .RESET (rst_b),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memories: word at address A is A | 0x13, one-cycle latency.
    initial bus_a.IMEM_RDATA = 32'h0;
    initial bus_b.IMEM_RDATA = 32'h0;
    always @(posedge clk) begin
        if (bus_a.IMEM_REQ === 1'b1) bus_a.IMEM_RDATA <= bus_a.IMEM_ADDR | 32'h13;
        if (bus_b.IMEM_REQ === 1'b1) bus_b.IMEM_RDATA <= bus_b.IMEM_ADDR | 32'h13;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected decode head and memory request for one cycle; IR follows from PC.
    task automatic exp_a(input string tag, input logic ev, input logic [31:0] epc,
                         input logic ereq, input logic [31:0] eaddr);
        chk({tag, ".valid"}, 32'(bus_a.DE_VALID), 32'(ev));
        chk({tag, ".pc"},    bus_a.DE_PC, ev ? epc : 32'h0);
        chk({tag, ".ir"},    bus_a.DE_IR, ev ? (epc | 32'h13) : 32'h0000_0013);
        chk({tag, ".req"},   32'(bus_a.IMEM_REQ), 32'(ereq));
        if (ereq) chk({tag, ".addr"}, bus_a.IMEM_ADDR, eaddr);
    endtask

    task automatic exp_b(input string tag, input logic ev, input logic [31:0] epc,
                         input logic ereq, input logic [31:0] eaddr);
        chk({tag, ".valid"}, 32'(bus_b.DE_VALID), 32'(ev));
        chk({tag, ".pc"},    bus_b.DE_PC, ev ? epc : 32'h0);
        chk({tag, ".ir"},    bus_b.DE_IR, ev ? (epc | 32'h13) : 32'h0000_0013);
        chk({tag, ".req"},   32'(bus_b.IMEM_REQ), 32'(ereq));
        if (ereq) chk({tag, ".addr"}, bus_b.IMEM_ADDR, eaddr);
    endtask

    // Advance to the next cycle's low phase, apply inputs, let them settle.
    task automatic step_a(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        bus_a.DE_READY    = rdy;
        bus_a.REDIRECT    = redir;
        bus_a.REDIRECT_PC = rpc;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.DE_READY = 1'b1; bus_a.REDIRECT = 1'b0; bus_a.REDIRECT_PC = 32'h0;
        bus_b.DE_READY = 1'b1; bus_b.REDIRECT = 1'b0; bus_b.REDIRECT_PC = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        exp_a("rst", 1'b0, 32'h0, 1'b0, 32'h0);

        // 1: stream from reset vector
        @(negedge clk); rst_a = 1'b1; #1;
        exp_a("s_c0", 1'b0, 32'h0, 1'b1, 32'h0);
        step_a(1'b1, 1'b0, 32'h0);
        exp_a("s_c1", 1'b0, 32'h0, 1'b1, 32'h4);
        for (int n = 0; n < 4; n++) begin
            step_a(1'b1, 1'b0, 32'h0);
            exp_a("s_stream", 1'b1, 32'(4 * n), 1'b1, 32'(4 * (n + 2)));
        end

        // 2: stall five cycles; head 0x10 holds, requests stop
        for (int n = 0; n < 5; n++) begin
            step_a(1'b0, 1'b0, 32'h0);
            exp_a("stall", 1'b1, 32'h10, 1'b0, 32'h0);
        end
        for (int n = 0; n < 4; n++) begin
            step_a(1'b1, 1'b0, 32'h0);
            exp_a("resume", 1'b1, 32'(32'h10 + 4 * n), 1'b1, 32'(32'h18 + 4 * n));
        end

        // 3: redirect to 0x100 while 0x20 is buffered and 0x24 inflight
        step_a(1'b1, 1'b1, 32'h100);
        exp_a("rd100_c0", 1'b0, 32'h0, 1'b1, 32'h100);
        step_a(1'b1, 1'b0, 32'h0);
        exp_a("rd100_c1", 1'b0, 32'h0, 1'b1, 32'h104);
        step_a(1'b1, 1'b0, 32'h0);
        exp_a("rd100_c2", 1'b1, 32'h100, 1'b1, 32'h108);
        step_a(1'b1, 1'b0, 32'h0);
        exp_a("rd100_c3", 1'b1, 32'h104, 1'b1, 32'h10C);

        // 4: misaligned redirect target
        step_a(1'b1, 1'b1, 32'h203);
        exp_a("rd203_c0", 1'b0, 32'h0, 1'b1, 32'h200);
        step_a(1'b1, 1'b0, 32'h0);
        exp_a("rd203_c1", 1'b0, 32'h0, 1'b1, 32'h204);
        step_a(1'b1, 1'b0, 32'h0);
        exp_a("rd203_c2", 1'b1, 32'h200, 1'b1, 32'h208);
        step_a(1'b1, 1'b0, 32'h0);
        exp_a("rd203_c3", 1'b1, 32'h204, 1'b1, 32'h20C);

        // 5: back-to-back redirects, only the second stream survives
        step_a(1'b1, 1'b1, 32'h40);
        exp_a("rd40", 1'b0, 32'h0, 1'b1, 32'h40);
        step_a(1'b1, 1'b1, 32'h80);
        exp_a("rd80", 1'b0, 32'h0, 1'b1, 32'h80);
        step_a(1'b1, 1'b0, 32'h0);
        exp_a("rd80_c1", 1'b0, 32'h0, 1'b1, 32'h84);
        for (int n = 0; n < 3; n++) begin
            step_a(1'b1, 1'b0, 32'h0);
            exp_a("rd80_stream", 1'b1, 32'(32'h80 + 4 * n), 1'b1, 32'(32'h88 + 4 * n));
        end

        // 6: wrap-around reset vector, then mid-stream reset
        @(negedge clk); rst_b = 1'b1; #1;
        exp_b("w_c0", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        exp_b("w_c1", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        exp_b("w_c2", 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0);
        @(negedge clk); #1;
        exp_b("w_c3", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h4);
        @(negedge clk); #1;
        exp_b("w_c4", 1'b1, 32'h0, 1'b1, 32'h8);
        #1; rst_b = 1'b0; #1;
        exp_b("w_rst_now", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk); #1;
        exp_b("w_rst_hold", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk); rst_b = 1'b1; #1;
        exp_b("w_rel_c0", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        exp_b("w_rel_c1", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        exp_b("w_rel_c2", 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
